prog_sequencer: RTL and testbench

- Instruction-fetch/execute controller. It reads the 4-word, 2-bit-wide program ROM: drives the ROM address and consumes the combinational opcode that comes back.
- Executes the three-opcode ISA:
  - INC=00
  - JNO=01, followed by a target-address word
  - HLT=10
- Maintains the accumulator and the overflow flag.
- Sits between the program ROM and the datapath/status logic.

---
 rtl/prog_sequencer.sv | 136 +++++++++++++
 tb/tb_prog_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - fetch/execute controller for the INC/JNO/HLT program ROM
// Optional retired-instruction counter and port under SEQ_RETIRE_CNT_EN.
module prog_sequencer #(
   parameter int         ACC_W    = 4,
   parameter logic [1:0] START_PC = 2'd0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [1:0]       addr,
   input  logic [1:0]       instr,
   output logic [ACC_W-1:0] acc,
   output logic             ovf,
   output logic             busy,
   output logic             halted,
   output logic             err
`ifdef SEQ_RETIRE_CNT_EN
   ,
   output logic [7:0]       retired
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_OPER  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_JNO = 2'b01;
   localparam logic [1:0] OP_HLT = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [1:0]       pc_q, pc_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             halted_q, halted_d;
   logic             start_act;

   assign start_act = start && (state_q == S_IDLE || state_q == S_HALT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start_act) begin
               pc_d    = START_PC;
               acc_d   = '0;
               ovf_d   = 1'b0;
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            case (instr)
               OP_INC: begin
                  acc_d = acc_q + 1'b1;
                  if (&acc_q) ovf_d = 1'b1;
                  pc_d  = pc_q + 2'd1;
               end
               OP_JNO: begin
                  pc_d    = pc_q + 2'd1;
                  state_d = S_OPER;
               end
               OP_HLT: state_d = S_HALT;
               default: begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end
         default: begin
            // instr here is the operand word: the jump target
            pc_d    = ovf_q ? pc_q + 2'd1 : instr;
            state_d = S_FETCH;
         end
      endcase
      busy_d   = (state_d == S_FETCH) || (state_d == S_OPER);
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= 2'd0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         halted_q <= halted_d;
      end
   end

   assign addr   = pc_q;
   assign acc    = acc_q;
   assign ovf    = ovf_q;
   assign err    = err_q;
   assign busy   = busy_q;
   assign halted = halted_q;

`ifdef SEQ_RETIRE_CNT_EN
   logic [7:0] ret_q, ret_d;
   logic       retire;

   // Illegal opcodes halt without retiring
   always_comb begin
      retire = 1'b0;
      if (state_q == S_OPER) retire = 1'b1;
      else if (state_q == S_FETCH && (instr == OP_INC || instr == OP_HLT)) retire = 1'b1;
      ret_d = ret_q;
      if (start_act) ret_d = 8'd0;
      else if (retire && ret_q != 8'hFF) ret_d = ret_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ret_q <= 8'd0;
      else     ret_q <= ret_d;
   end

   assign retired = ret_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - scoreboard bench for prog_sequencer
// Covers the default build and SEQ_RETIRE_CNT_EN builds.
module tb_prog_sequencer;

   typedef struct {
      string      name;
      logic [3:0] acc;
      logic       ovf;
      logic       err;
      logic [1:0] addr;
      int         edges;
      int         retired;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [1:0] addr;
   logic [1:0] instr;
   logic [3:0] acc;
   logic       ovf, busy, halted, err;
   logic [1:0] rom [4];
   logic       halted_prev = 1'b0;
   int         edges = 0;
   int         vectors = 0;
   int         miscompares = 0;
   exp_t       exp_q [$];
   logic [1:0] trace_q [$];
`ifdef SEQ_RETIRE_CNT_EN
   logic [7:0] retired;
`endif

   prog_sequencer #(.ACC_W(4), .START_PC(2'd0)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .addr   (addr),
      .instr  (instr),
      .acc    (acc),
      .ovf    (ovf),
      .busy   (busy),
      .halted (halted),
      .err    (err)
`ifdef SEQ_RETIRE_CNT_EN
      ,
      .retired(retired)
`endif
   );

   always #5 clk = ~clk;
   assign instr = rom[addr];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // edges since (and including) the accepted start edge
   always @(posedge clk or posedge rst) begin
      if (rst) edges <= 0;
      else if (start && !busy) edges <= 1;
      else edges <= edges + 1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (busy && trace_q.size() > 0) check("pc_trace", addr, trace_q.pop_front());
         if (halted && !halted_prev) begin
            if (exp_q.size() == 0) check("unexpected_halt", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               check({e.name, "_edges"}, edges, e.edges);
               check({e.name, "_acc"}, acc, e.acc);
               check({e.name, "_ovf"}, ovf, e.ovf);
               check({e.name, "_err"}, err, e.err);
               check({e.name, "_addr"}, addr, e.addr);
`ifdef SEQ_RETIRE_CNT_EN
               check({e.name, "_retired"}, retired, e.retired);
`endif
            end
         end
      end
      halted_prev <= halted;
   end

   task automatic load(input logic [1:0] r0, r1, r2, r3);
      rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = r3;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (!halted && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!halted) check({name, "_timeout"}, halted, 1);
      @(negedge clk);
   endtask

   task automatic push(input string name, input logic [3:0] a, input logic o, input logic e,
                       input logic [1:0] ad, input int ed, input int rt);
      exp_t x;
      x.name = name; x.acc = a; x.ovf = o; x.err = e; x.addr = ad; x.edges = ed; x.retired = rt;
      exp_q.push_back(x);
   endtask

   task automatic check_reset(input string name);
      check({name, "_acc"}, acc, 0);
      check({name, "_addr"}, addr, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_halted"}, halted, 0);
      check({name, "_ovf"}, ovf, 0);
      check({name, "_err"}, err, 0);
   endtask

   initial begin
      int n;
      load(2'b00, 2'b01, 2'b00, 2'b10);
      #1 rst = 1'b1;
      #2 check_reset("por");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset while running with acc=5, checked before any further edge
      pulse_start();
      n = 0;
      while (acc != 4'd5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("pre_rst_acc", acc, 5);
      check("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1 check_reset("mid_rst");
      @(negedge clk) rst = 1'b0;

      push("canon", 4'd0, 1'b1, 1'b0, 2'd3, 50, 33);
      pulse_start();
      wait_halt("canon");

      // rerun from HALT with a start pulse while busy that must be ignored
      push("rerun", 4'd0, 1'b1, 1'b0, 2'd3, 50, 33);
      pulse_start();
      repeat (5) @(negedge clk);
      check("rerun_busy", busy, 1);
      check("rerun_ovf_cleared", ovf, 0);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_halt("rerun");

      load(2'b00, 2'b00, 2'b10, 2'b00);
      push("inc2", 4'd2, 1'b0, 1'b0, 2'd2, 4, 3);
      pulse_start();
      wait_halt("inc2");

      load(2'b11, 2'b00, 2'b00, 2'b00);
      push("illegal", 4'd0, 1'b0, 1'b1, 2'd0, 2, 0);
      pulse_start();
      wait_halt("illegal");

      load(2'b01, 2'b01, 2'b10, 2'b00);
      trace_q = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
      push("selfjno", 4'd0, 1'b0, 1'b0, 2'd2, 6, 3);
      pulse_start();
      wait_halt("selfjno");

      repeat (2) @(negedge clk);
      check("sb_exp_left", exp_q.size(), 0);
      check("sb_trace_left", trace_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
